// File: rtl/tpu_thread_recv_if.sv
// rtl/tpu_thread_recv_if.sv - MPU dispatch, IMem write, sequencer and commit signals of tpu_thread_recv
interface tpu_thread_recv_if #(
    parameter int WIDTH_INSTR     = 64,
    parameter int WIDTH_DATA      = 32,
    parameter int WIDTH_THREADID  = 32,
    parameter int WIDTH_NUM_ISSUE = 3,
    parameter int DEPTH_IMEM      = 1024
);
    localparam int WIDTH_IA = $clog2(DEPTH_IMEM);

    logic                       I_V;
    logic [2:0]                 I_Tag;
    logic [WIDTH_INSTR-1:0]     I_Instr;
    logic [WIDTH_DATA-1:0]      I_Data;
    logic                       O_Rdy;
    logic                       O_IMem_We;
    logic [WIDTH_IA-1:0]        O_IMem_Addr;
    logic [WIDTH_INSTR-1:0]     O_IMem_Data;
    logic [WIDTH_THREADID-1:0]  O_ThreadID;
    logic [WIDTH_IA:0]          O_Length;
    logic                       O_Start;
    logic                       I_End;
    logic                       O_Commit;
    logic [WIDTH_NUM_ISSUE-1:0] O_IssueNo;
    logic                       I_Commit_Ack;
    logic                       O_Err;

    modport master (
        output I_V, I_Tag, I_Instr, I_Data, I_End, I_Commit_Ack,
        input  O_Rdy, O_IMem_We, O_IMem_Addr, O_IMem_Data, O_ThreadID, O_Length,
        input  O_Start, O_Commit, O_IssueNo, O_Err
    );

    modport slave (
        input  I_V, I_Tag, I_Instr, I_Data, I_End, I_Commit_Ack,
        output O_Rdy, O_IMem_We, O_IMem_Addr, O_IMem_Data, O_ThreadID, O_Length,
        output O_Start, O_Commit, O_IssueNo, O_Err
    );
endinterface

// File: rtl/tpu_thread_recv.sv
// rtl/tpu_thread_recv.sv - TPU thread-dispatch receiver: loads IMem, launches thread, returns commit
// Optional length check on the ILENGTH word: define TPU_RECV_LENGTH_CHECK_EN.
module tpu_thread_recv #(
    parameter int WIDTH_INSTR     = 64,
    parameter int WIDTH_DATA      = 32,
    parameter int WIDTH_THREADID  = 32,
    parameter int WIDTH_NUM_ISSUE = 3,
    parameter int DEPTH_IMEM      = 1024
) (
    input logic               clock,
    input logic               reset,
    tpu_thread_recv_if.slave  bus
);
    localparam int WIDTH_IA = $clog2(DEPTH_IMEM);
    localparam logic [WIDTH_IA:0] COUNT_FULL = (WIDTH_IA+1)'(DEPTH_IMEM);
    localparam logic [WIDTH_IA:0] COUNT_LAST = COUNT_FULL - 1'b1;

    localparam logic [2:0] TAG_ID    = 3'd2;
    localparam logic [2:0] TAG_INSTR = 3'd3;
    localparam logic [2:0] TAG_ISSUE = 3'd4;
    localparam logic [2:0] TAG_LEN   = 3'd5;

    typedef enum logic [2:0] {
        S_ID, S_INSTR, S_ISSUE, S_LEN, S_START, S_RUN, S_COMMIT
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH_IA:0]          count;
    logic [WIDTH_THREADID-1:0]  thread_id;
    logic [WIDTH_NUM_ISSUE-1:0] issue_no;
    logic [WIDTH_IA:0]          length;
    logic                       err;
    logic                       imem_we;
    logic [WIDTH_IA-1:0]        imem_addr;
    logic [WIDTH_INSTR-1:0]     imem_data;

    logic accept;
    logic wr_en, latch_id, latch_issue, latch_len, set_err;

    assign accept = bus.I_V && bus.O_Rdy;

    always_comb begin
        state_nxt   = state;
        wr_en       = 1'b0;
        latch_id    = 1'b0;
        latch_issue = 1'b0;
        latch_len   = 1'b0;
        set_err     = 1'b0;
        case (state)
            S_ID: if (accept) begin
                if (bus.I_Tag == TAG_ID) begin
                    latch_id  = 1'b1;
                    state_nxt = S_INSTR;
                end else begin
                    set_err = 1'b1;
                end
            end
            S_INSTR: if (accept) begin
                if (bus.I_Tag == TAG_INSTR && count != COUNT_FULL) begin
                    wr_en = 1'b1;
                    // Last free slot filled: only the issue word may follow.
                    if (count == COUNT_LAST) state_nxt = S_ISSUE;
                end else if (bus.I_Tag == TAG_ISSUE) begin
                    latch_issue = 1'b1;
                    state_nxt   = S_LEN;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_ID;
                end
            end
            S_ISSUE: if (accept) begin
                if (bus.I_Tag == TAG_ISSUE) begin
                    latch_issue = 1'b1;
                    state_nxt   = S_LEN;
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_ID;
                end
            end
            S_LEN: if (accept) begin
                if (bus.I_Tag == TAG_LEN) begin
                    latch_len = 1'b1;
`ifdef TPU_RECV_LENGTH_CHECK_EN
                    if (bus.I_Data[WIDTH_IA:0] != count) begin
                        set_err   = 1'b1;
                        state_nxt = S_ID;
                    end else begin
                        state_nxt = S_START;
                    end
`else
                    state_nxt = S_START;
`endif
                end else begin
                    set_err   = 1'b1;
                    state_nxt = S_ID;
                end
            end
            S_START:  state_nxt = S_RUN;
            S_RUN:    if (bus.I_End) state_nxt = S_COMMIT;
            S_COMMIT: if (bus.I_Commit_Ack) state_nxt = S_ID;
            default:  state_nxt = S_ID;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_ID;
        else       state <= state_nxt;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count     <= '0;
            thread_id <= '0;
            issue_no  <= '0;
            length    <= '0;
            err       <= 1'b0;
            imem_we   <= 1'b0;
            imem_addr <= '0;
            imem_data <= '0;
        end else begin
            imem_we <= wr_en;
            if (wr_en) begin
                imem_addr <= count[WIDTH_IA-1:0];
                imem_data <= bus.I_Instr;
                count     <= count + 1'b1;
            end
            if (latch_id) begin
                thread_id <= bus.I_Data[WIDTH_THREADID-1:0];
                count     <= '0;
            end
            if (latch_issue) issue_no <= bus.I_Data[WIDTH_NUM_ISSUE-1:0];
            if (latch_len)   length   <= count;
            if (set_err)     err      <= 1'b1;
        end
    end

    // Ready is held low while reset is asserted so every output reads zero.
    assign bus.O_Rdy       = !reset && (state == S_ID || state == S_INSTR ||
                                        state == S_ISSUE || state == S_LEN);
    assign bus.O_Start     = (state == S_START);
    assign bus.O_Commit    = (state == S_COMMIT);
    assign bus.O_IMem_We   = imem_we;
    assign bus.O_IMem_Addr = imem_addr;
    assign bus.O_IMem_Data = imem_data;
    assign bus.O_ThreadID  = thread_id;
    assign bus.O_Length    = length;
    assign bus.O_IssueNo   = issue_no;
    assign bus.O_Err       = err;
endmodule

// File: tb/tb_tpu_thread_recv.sv
// tb/tb_tpu_thread_recv.sv - scoreboard bench for tpu_thread_recv
module tb_tpu_thread_recv;
    localparam int DEPTH = 1024;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    tpu_thread_recv_if #(.WIDTH_INSTR(64), .WIDTH_DATA(32), .WIDTH_THREADID(32),
                         .WIDTH_NUM_ISSUE(3), .DEPTH_IMEM(DEPTH)) bus();

    tpu_thread_recv #(.WIDTH_INSTR(64), .WIDTH_DATA(32), .WIDTH_THREADID(32),
                      .WIDTH_NUM_ISSUE(3), .DEPTH_IMEM(DEPTH))
        dut (.clock(clock), .reset(reset), .bus(bus.slave));

    typedef struct {logic [9:0] addr; logic [63:0] data; int cyc;} wr_t;
    typedef struct {logic [31:0] tid; logic [10:0] len; int cyc;} st_t;
    typedef struct {logic [2:0] issue; int cyc;} cm_t;

    wr_t wq[$];
    st_t sq[$];
    cm_t cq[$];

    int cyc = 0;
    int n_pass = 0;
    int n_total = 0;
    logic commit_d = 1'b0;
    wr_t mw;
    st_t ms;
    cm_t mc;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: compares every DUT output event against the queued expectations.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.O_IMem_We) begin
                check("write_expected", 64'(wq.size() > 0), 1);
                if (wq.size() > 0) begin
                    mw = wq.pop_front();
                    check("wr_addr", 64'(bus.O_IMem_Addr), 64'(mw.addr));
                    check("wr_data", bus.O_IMem_Data, mw.data);
                    check("wr_cycle", 64'(cyc), 64'(mw.cyc));
                end
            end
            if (bus.O_Start) begin
                check("start_expected", 64'(sq.size() > 0), 1);
                if (sq.size() > 0) begin
                    ms = sq.pop_front();
                    check("start_tid", 64'(bus.O_ThreadID), 64'(ms.tid));
                    check("start_len", 64'(bus.O_Length), 64'(ms.len));
                    check("start_cycle", 64'(cyc), 64'(ms.cyc));
                end
            end
            if (bus.O_Commit && !commit_d) begin
                check("commit_expected", 64'(cq.size() > 0), 1);
                check("rdy_low_in_commit", 64'(bus.O_Rdy), 0);
                if (cq.size() > 0) begin
                    mc = cq.pop_front();
                    check("commit_issue", 64'(bus.O_IssueNo), 64'(mc.issue));
                    check("commit_cycle", 64'(cyc), 64'(mc.cyc));
                end
            end
        end
        commit_d <= bus.O_Commit && !reset;
    end

    task automatic send(input logic [2:0] tag, input logic [31:0] data,
                        input logic [63:0] instr, output int acc);
        bit done = 0;
        @(negedge clock);
        bus.I_V = 1'b1; bus.I_Tag = tag; bus.I_Data = data; bus.I_Instr = instr;
        acc = -1;
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.O_Rdy) begin
                acc = cyc;
                @(posedge clock);
                #1 bus.I_V = 1'b0;
                done = 1;
            end else begin
                @(negedge clock);
            end
        end
        if (!done) begin
            check("rdy_within_bound", 64'(bus.O_Rdy), 1);
            bus.I_V = 1'b0;
        end
    endtask

    task automatic hdr(input logic [31:0] tid);
        int c;
        send(3'd2, tid, 64'd0, c);
    endtask

    task automatic instr(input logic [63:0] d, input logic [9:0] addr);
        int c;
        send(3'd3, 32'd0, d, c);
        wq.push_back('{addr, d, c + 1});
    endtask

    task automatic issue(input logic [2:0] n);
        int c;
        send(3'd4, {29'd0, n}, 64'd0, c);
    endtask

    task automatic len(input logic [31:0] l, input bit exp_start,
                       input logic [31:0] tid, input logic [10:0] cnt);
        int c;
        send(3'd5, l, 64'd0, c);
        if (exp_start) sq.push_back('{tid, cnt, c + 1});
    endtask

    task automatic finish_thread(input logic [2:0] n);
        bit seen = 0;
        @(negedge clock);
        @(negedge clock);
        bus.I_End = 1'b1;
        cq.push_back('{n, cyc + 1});
        @(posedge clock);
        #1 bus.I_End = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (bus.O_Commit) seen = 1;
        end
        check("commit_within_bound", 64'(seen), 1);
        bus.I_Commit_Ack = 1'b1;
        @(posedge clock);
        #1 bus.I_Commit_Ack = 1'b0;
        @(negedge clock);
        check("rdy_after_ack", 64'(bus.O_Rdy), 1);
        check("commit_dropped", 64'(bus.O_Commit), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rdy"},    64'(bus.O_Rdy), 0);
        check({tag, "_we"},     64'(bus.O_IMem_We), 0);
        check({tag, "_start"},  64'(bus.O_Start), 0);
        check({tag, "_commit"}, 64'(bus.O_Commit), 0);
        check({tag, "_tid"},    64'(bus.O_ThreadID), 0);
        check({tag, "_len"},    64'(bus.O_Length), 0);
        check({tag, "_issue"},  64'(bus.O_IssueNo), 0);
        check({tag, "_err"},    64'(bus.O_Err), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("rdy_after_reset", 64'(bus.O_Rdy), 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.I_V = 1'b0; bus.I_Tag = 3'd0; bus.I_Data = '0; bus.I_Instr = '0;
        bus.I_End = 1'b0; bus.I_Commit_Ack = 1'b0;
        repeat (2) @(negedge clock);
        do_reset();

        // Basic thread: three instructions, issue 5
        hdr(32'h12);
        instr(64'hAAAA_0000_0000_000A, 10'd0);
        instr(64'hBBBB_0000_0000_000B, 10'd1);
        instr(64'hCCCC_0000_0000_000C, 10'd2);
        issue(3'd5);
        len(32'd3, 1, 32'h12, 11'd3);
        finish_thread(3'd5);

        // Zero-instruction thread
        hdr(32'h34);
        issue(3'd2);
        len(32'd0, 1, 32'h34, 11'd0);
        finish_thread(3'd2);
        check("err_clean_threads", 64'(bus.O_Err), 0);

        // Length word disagreeing with received count
        hdr(32'h21);
        instr(64'hEEEE, 10'd0);
        instr(64'hFFFF, 10'd1);
        issue(3'd4);
`ifdef TPU_RECV_LENGTH_CHECK_EN
        len(32'd4, 0, 32'h21, 11'd2);
        repeat (4) @(negedge clock);
        check("len_mismatch_err", 64'(bus.O_Err), 1);
        check("len_mismatch_rdy", 64'(bus.O_Rdy), 1);
`else
        len(32'd4, 1, 32'h21, 11'd2);
        finish_thread(3'd4);
        check("len_nocheck_err", 64'(bus.O_Err), 0);
`endif
        do_reset();

        // Fill the instruction memory, then overflow by one
        hdr(32'h99);
        for (int i = 0; i < DEPTH; i++) instr({32'hC0DE_0000, 32'(i)}, 10'(i));
        begin
            int c;
            send(3'd3, 32'd0, 64'hDEAD, c);
        end
        @(negedge clock);
        check("overflow_err", 64'(bus.O_Err), 1);
        check("overflow_rdy", 64'(bus.O_Rdy), 1);
        hdr(32'hAB);
        issue(3'd1);
        len(32'd0, 1, 32'hAB, 11'd0);
        finish_thread(3'd1);
        do_reset();

        // Instruction tag while waiting for a thread ID
        begin
            int c;
            send(3'd3, 32'd0, 64'h5151, c);
        end
        @(negedge clock);
        check("bad_tag_err", 64'(bus.O_Err), 1);
        check("bad_tag_rdy", 64'(bus.O_Rdy), 1);
        hdr(32'h56);
        instr(64'hD00D, 10'd0);
        issue(3'd7);
        len(32'd1, 1, 32'h56, 11'd1);
        finish_thread(3'd7);
        check("err_sticky", 64'(bus.O_Err), 1);
        do_reset();

        // Reset while the thread is running
        hdr(32'h77);
        instr(64'h7777, 10'd0);
        issue(3'd3);
        len(32'd1, 1, 32'h77, 11'd1);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_all_zero("run_reset");
        reset = 1'b0;
        bus.I_End = 1'b1;
        @(negedge clock);
        bus.I_End = 1'b0;
        repeat (5) @(negedge clock);
        check("no_commit_after_reset", 64'(bus.O_Commit), 0);
        check("rdy_after_run_reset", 64'(bus.O_Rdy), 1);

        repeat (5) @(negedge clock);
        check("writes_drained", 64'(wq.size()), 0);
        check("starts_drained", 64'(sq.size()), 0);
        check("commits_drained", 64'(cq.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
